// File: rtl/display_pkg.sv
// display_pkg: digit ordering and sizing constants shared by the display datapath.
package display_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int SEL_W = 2;
  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [NUM_DIGITS-1:0] dig_en_t;
  localparam sel_t DIG1_SEL = 2'd0;
  localparam sel_t DIG2_SEL = 2'd1;
  localparam sel_t DIG3_SEL = 2'd2;
  localparam sel_t DIG4_SEL = 2'd3;
  localparam int DIG1_EN_BIT = 3;
  localparam int DIG2_EN_BIT = 2;
  localparam int DIG3_EN_BIT = 1;
  localparam int DIG4_EN_BIT = 0;
  localparam logic [3:0] BCD_ZERO = 4'd0;
  function automatic int cnt_width(input int modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction
endpackage

// File: rtl/mod_counter.sv
// mod_counter: modulus counter with count-enable; wrap_o flags the wrapping edge,
// tick_o is the registered one-cycle pulse that follows it.
module mod_counter
  import display_pkg::*;
#(
  parameter int MOD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic wrap_o,
  output logic tick_o
);
  localparam int W = cnt_width(MOD);
  logic [W-1:0] count_q, count_d;
  logic tick_q;
  assign wrap_o = en_i & (count_q == W'(MOD - 1));
  assign count_d = wrap_o ? '0 : en_i ? count_q + W'(1) : count_q;
  assign tick_o = tick_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      tick_q <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q <= wrap_o;
    end
  end
endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: digit-slot scan sequencing, blink phase and registered
// digit/dot enables for the 4-digit 7-segment display.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int SCAN_DIV = 12000,
  parameter int BLINK_HALF = 125
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic [NUM_DIGITS-1:0] i_Digits_On,
  input  logic [NUM_DIGITS-1:0] i_Blink_Mask,
  input  logic                  i_Dot_On,
  input  logic                  i_Dot_Blink,
  input  logic                  i_Lead_Zero_Blank,
  input  logic [3:0]            i_Data_Dig1,
  output logic [SEL_W-1:0]      o_Select,
  output logic [NUM_DIGITS-1:0] o_Enable_Digits,
  output logic                  o_Enable_Dot,
  output logic                  o_Slot_Tick,
  output logic                  o_Blink_Phase
);
  logic pre_wrap, frame_en, frame_wrap, frame_tick_unused;
  sel_t sel_q, sel_d;
  logic phase_q, phase_d;
  dig_en_t en_q, en_d;
  logic dot_q, dot_d;
  mod_counter #(.MOD(SCAN_DIV)) u_prescaler (
    .clk    (i_Clk),
    .rst    (i_Reset),
    .en_i   (1'b1),
    .wrap_o (pre_wrap),
    .tick_o (o_Slot_Tick)
  );
  // The frame counter must step on the same edge the select wraps, so it is
  // enabled from the combinational prescaler wrap rather than the registered tick.
  assign frame_en = pre_wrap & (sel_q == DIG4_SEL);
  mod_counter #(.MOD(BLINK_HALF)) u_frame (
    .clk    (i_Clk),
    .rst    (i_Reset),
    .en_i   (frame_en),
    .wrap_o (frame_wrap),
    .tick_o (frame_tick_unused)
  );
  always_comb begin
    sel_d = pre_wrap ? sel_q + sel_t'(1) : sel_q;
    phase_d = phase_q ^ frame_wrap;
    en_d = i_Digits_On & ~(i_Blink_Mask & {NUM_DIGITS{phase_q}});
    en_d[DIG1_EN_BIT] = en_d[DIG1_EN_BIT] & ~(i_Lead_Zero_Blank & (i_Data_Dig1 == BCD_ZERO));
    dot_d = i_Dot_On & ~(i_Dot_Blink & phase_q);
  end
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      sel_q <= DIG1_SEL;
      phase_q <= 1'b0;
      en_q <= '0;
      dot_q <= 1'b0;
    end else begin
      sel_q <= sel_d;
      phase_q <= phase_d;
      en_q <= en_d;
      dot_q <= dot_d;
    end
  end
  assign o_Select = sel_q;
  assign o_Blink_Phase = phase_q;
  assign o_Enable_Digits = en_q;
  assign o_Enable_Dot = dot_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed checks of scan timing, blink, blanking, dot and reset.
module tb_display_scan_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] digits_on = 4'b0000;
  logic [3:0] blink_mask = 4'b0000;
  logic dot_on = 1'b0;
  logic dot_blink = 1'b0;
  logic lzb = 1'b0;
  logic [3:0] dig1 = 4'd5;
  logic [1:0] sel;
  logic [3:0] en_dig;
  logic en_dot, tick, phase;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  display_scan_ctrl #(.SCAN_DIV(4), .BLINK_HALF(2)) dut (
    .i_Clk             (clk),
    .i_Reset           (rst),
    .i_Digits_On       (digits_on),
    .i_Blink_Mask      (blink_mask),
    .i_Dot_On          (dot_on),
    .i_Dot_Blink       (dot_blink),
    .i_Lead_Zero_Blank (lzb),
    .i_Data_Dig1       (dig1),
    .o_Select          (sel),
    .o_Enable_Digits   (en_dig),
    .o_Enable_Dot      (en_dot),
    .o_Slot_Tick       (tick),
    .o_Blink_Phase     (phase)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic scan_inputs();
    digits_on = 4'b1111;
    blink_mask = 4'b1000;
    dot_on = 1'b1;
    dot_blink = 1'b1;
    lzb = 1'b0;
    dig1 = 4'd5;
  endtask

  // Edge n counts from the first edge with reset low; select steps at n=4,8,..
  // and the phase toggles every 32 edges; enables lag the phase by one edge.
  task automatic run_scan_check(input int ncyc);
    for (int n = 1; n <= ncyc; n++) begin
      int p_now, p_prev;
      logic [1:0] exp_sel;
      logic [3:0] exp_en;
      step();
      p_now = (n / 32) % 2;
      p_prev = ((n - 1) / 32) % 2;
      exp_sel = 2'((n / 4) % 4);
      exp_en = p_prev ? 4'b0111 : 4'b1111;
      tests++;
      if (sel !== exp_sel) begin
        fails++;
        $display("FAIL scan_select n=%0d got %0d want %0d", n, sel, exp_sel);
      end
      tests++;
      if (tick !== ((n % 4) == 0)) begin
        fails++;
        $display("FAIL scan_tick n=%0d got %b want %b", n, tick, (n % 4) == 0);
      end
      tests++;
      if (phase !== 1'(p_now)) begin
        fails++;
        $display("FAIL blink_phase n=%0d got %b want %0d", n, phase, p_now);
      end
      tests++;
      if (en_dig !== exp_en) begin
        fails++;
        $display("FAIL blink_enables n=%0d got %b want %b", n, en_dig, exp_en);
      end
      tests++;
      if (en_dot !== 1'(1 - p_prev)) begin
        fails++;
        $display("FAIL dot_blink n=%0d got %b want %0d", n, en_dot, 1 - p_prev);
      end
    end
  endtask

  task automatic check_zero(input string name);
    tests++;
    if ({sel, en_dig, en_dot, tick, phase} !== 9'b0) begin
      fails++;
      $display("FAIL %s got sel=%0d en=%b dot=%b tick=%b phase=%b want all 0",
               name, sel, en_dig, en_dot, tick, phase);
    end
  endtask

  task automatic test_reset();
    scan_inputs();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check_zero("reset_state");
    rst = 1'b0;
    run_scan_check(70);
  endtask

  task automatic test_lead_zero();
    scan_inputs();
    blink_mask = 4'b0000;
    do_reset();
    lzb = 1'b1;
    dig1 = 4'd0;
    step();
    tests++;
    if (en_dig !== 4'b0111) begin
      fails++;
      $display("FAIL lzb_zero got %b want 0111", en_dig);
    end
    dig1 = 4'd1;
    step();
    tests++;
    if (en_dig !== 4'b1111) begin
      fails++;
      $display("FAIL lzb_one got %b want 1111", en_dig);
    end
    lzb = 1'b0;
    dig1 = 4'd0;
    step();
    tests++;
    if (en_dig !== 4'b1111) begin
      fails++;
      $display("FAIL lzb_off got %b want 1111", en_dig);
    end
  endtask

  task automatic test_dot();
    scan_inputs();
    dot_blink = 1'b0;
    do_reset();
    for (int n = 1; n <= 70; n++) begin
      step();
      tests++;
      if (en_dot !== 1'b1) begin
        fails++;
        $display("FAIL dot_steady n=%0d got %b want 1", n, en_dot);
      end
    end
    dot_on = 1'b0;
    dot_blink = 1'b1;
    for (int n = 0; n < 40; n++) begin
      step();
      tests++;
      if (en_dot !== 1'b0) begin
        fails++;
        $display("FAIL dot_off n=%0d got %b want 0", n, en_dot);
      end
    end
  endtask

  task automatic test_mid_reset();
    scan_inputs();
    do_reset();
    run_scan_check(42);
    tests++;
    if (sel !== 2'd2 || phase !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset_setup got sel=%0d phase=%b want sel=2 phase=1", sel, phase);
    end
    rst = 1'b1;
    step();
    check_zero("mid_reset_clear");
    rst = 1'b0;
    run_scan_check(70);
  endtask

  task automatic test_override();
    digits_on = 4'b0000;
    blink_mask = 4'b1111;
    lzb = 1'b1;
    dig1 = 4'd0;
    do_reset();
    for (int n = 1; n <= 70; n++) begin
      step();
      tests++;
      if (en_dig !== 4'b0000) begin
        fails++;
        $display("FAIL override n=%0d got %b want 0000 (phase %b)", n, en_dig, phase);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lead_zero();
    test_dot();
    test_mid_reset();
    test_override();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
